// File: rtl/cpu_sysctl.sv
// cpu_sysctl: System86 main-CPU memory-map decode plus edge-latched interrupts,
// a frame-counting watchdog and the timed nMRES reset pulse generator.
module cpu_sysctl #(
    parameter int unsigned IRQ_CHANNELS    = 2,
    parameter logic [4:0]  ACK_BASE        = 5'b10001,
    parameter logic [4:0]  KICK_PAGE       = 5'b10000,
    parameter int unsigned WATCHDOG_WIDTH  = 8,
    parameter int unsigned WATCHDOG_LIMIT  = 8,
    parameter bit          WATCHDOG_ENABLE = 1'b1,
    parameter int unsigned RESET_CYCLES    = 64
) (
    input  logic                      CLK_6M,
    input  logic                      RST,
    input  logic [15:11]              MA,
    input  logic                      nMWE,
    input  logic                      nVBLA,
    input  logic [IRQ_CHANNELS-1:0]   nIRQ_SRC,
    output logic                      nMRES,
    output logic [IRQ_CHANNELS-1:0]   nIRQ,
    output logic [WATCHDOG_WIDTH-1:0] WDOG_COUNT,
    output logic                      nMCS0,
    output logic                      nMCS1,
    output logic                      nMCS2,
    output logic                      nMCS4,
    output logic                      nMROM,
    output logic                      nLTH0,
    output logic                      nLTH1
);

    localparam int unsigned HOLD_W = $clog2(RESET_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [WATCHDOG_WIDTH-1:0] WD_FIRE_AT = WATCHDOG_WIDTH'(WATCHDOG_LIMIT - 1);
    localparam logic [WATCHDOG_WIDTH-1:0] WD_MAX = {WATCHDOG_WIDTH{1'b1}};

    typedef enum logic {
        S_HOLD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic [HOLD_W-1:0]         hold_cnt_q, hold_cnt_d;
    logic [WATCHDOG_WIDTH-1:0] wdog_q, wdog_d;
    logic [IRQ_CHANNELS-1:0]   irq_n_q, irq_n_d;
    logic                      nmres_q, nmres_d;

    logic [4:0]                ma_q, ma_d;
    logic                      mwe_n_q, mwe_n_d;
    logic                      mwe_n_prev_q, mwe_n_prev_d;
    logic                      vbla_n_q, vbla_n_d;
    logic                      vbla_n_prev_q, vbla_n_prev_d;
    logic [IRQ_CHANNELS-1:0]   src_n_q, src_n_d;
    logic [IRQ_CHANNELS-1:0]   src_n_prev_q, src_n_prev_d;

    logic                      write_ev;
    logic                      tick;
    logic                      kick;
    logic                      fire;
    logic [IRQ_CHANNELS-1:0]   src_ev;
    logic [IRQ_CHANNELS-1:0]   ack;

    // Memory-map decode straight from the address page; writes do not gate it.
    assign nMCS2 = ~(MA[15:13] == 3'b000);
    assign nMCS0 = ~(MA[15:13] == 3'b001);
    assign nMCS1 = ~(MA[15:13] == 3'b010);
    assign nMCS4 = ~(MA[15:13] == 3'b011);
    assign nMROM = ~MA[15];
    assign nLTH0 = ~(MA == 5'b11010);
    assign nLTH1 = ~(MA == 5'b11011);

    assign nMRES      = nmres_q;
    assign nIRQ       = irq_n_q;
    assign WDOG_COUNT = wdog_q;

    // Input stage: current/previous samples; keeps running during HOLD.
    always_comb begin
        ma_d          = MA;
        mwe_n_d       = nMWE;
        mwe_n_prev_d  = mwe_n_q;
        vbla_n_d      = nVBLA;
        vbla_n_prev_d = vbla_n_q;
        src_n_d       = nIRQ_SRC;
        src_n_prev_d  = src_n_q;
    end

    assign write_ev = mwe_n_prev_q & ~mwe_n_q;
    assign tick     = vbla_n_prev_q & ~vbla_n_q;
    assign src_ev   = src_n_prev_q & ~src_n_q;
    assign kick     = write_ev && (ma_q == KICK_PAGE);

    always_comb begin
        ack = '0;
        for (int i = 0; i < IRQ_CHANNELS; i++) begin
            ack[i] = write_ev && (ma_q == ACK_BASE + 5'(i));
        end
    end

    // A coincident kick clears the count, so it also suppresses the fire.
    assign fire = (state_q == S_RUN) && tick && !kick && WATCHDOG_ENABLE
                  && (wdog_q == WD_FIRE_AT);

    // Reset-pulse FSM: HOLD counts RESET_CYCLES edges, RUN waits for a fire.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            S_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = S_RUN;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            S_RUN: begin
                if (fire) begin
                    state_d    = S_HOLD;
                    hold_cnt_d = '0;
                end
            end
            default: begin
                state_d    = S_HOLD;
                hold_cnt_d = '0;
            end
        endcase
        nmres_d = (state_d == S_RUN);
    end

    // Watchdog counter and interrupt latches; both held clear while in reset.
    always_comb begin
        wdog_d  = wdog_q;
        irq_n_d = irq_n_q;
        if ((state_q == S_HOLD) || fire) begin
            wdog_d  = '0;
            irq_n_d = '1;
        end else begin
            if (kick) begin
                wdog_d = '0;
            end else if (tick && (wdog_q != WD_MAX)) begin
                wdog_d = wdog_q + WATCHDOG_WIDTH'(1);
            end
            irq_n_d = (irq_n_q | ack) & ~src_ev;
        end
    end

    always_ff @(posedge CLK_6M or posedge RST) begin
        if (RST) begin
            state_q       <= S_HOLD;
            hold_cnt_q    <= '0;
            wdog_q        <= '0;
            irq_n_q       <= '1;
            nmres_q       <= 1'b0;
            ma_q          <= '0;
            mwe_n_q       <= 1'b1;
            mwe_n_prev_q  <= 1'b1;
            vbla_n_q      <= 1'b1;
            vbla_n_prev_q <= 1'b1;
            src_n_q       <= '1;
            src_n_prev_q  <= '1;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            wdog_q        <= wdog_d;
            irq_n_q       <= irq_n_d;
            nmres_q       <= nmres_d;
            ma_q          <= ma_d;
            mwe_n_q       <= mwe_n_d;
            mwe_n_prev_q  <= mwe_n_prev_d;
            vbla_n_q      <= vbla_n_d;
            vbla_n_prev_q <= vbla_n_prev_d;
            src_n_q       <= src_n_d;
            src_n_prev_q  <= src_n_prev_d;
        end
    end

endmodule

// File: tb/tb_cpu_sysctl.sv
// Bench for cpu_sysctl: directed scenarios plus randomized bus activity checked
// against an edge-level behavioural model of interrupts, watchdog and reset pulse.
module tb_cpu_sysctl;

    localparam int unsigned N     = 2;
    localparam int          RC    = 64;
    localparam int          LIMIT = 8;
    localparam int          WMAX  = 255;
    localparam logic [4:0]  KICK  = 5'b10000;
    localparam logic [4:0]  ACK0  = 5'b10001;
    localparam logic [4:0]  ACK1  = 5'b10010;

    logic         clk;
    logic         rst;
    logic [4:0]   ma;
    logic         mwe_n;
    logic         vbla_n;
    logic [N-1:0] src_n;

    logic         nmres, nmres2;
    logic [N-1:0] nirq, nirq2;
    logic [7:0]   wdog, wdog2;
    logic         mcs0, mcs1, mcs2, mcs4, mrom, lth0, lth1;
    logic [6:0]   cs2;

    int errors = 0;
    int checks = 0;

    // Model state: edges since reset, edge count at which nMRES rises,
    // watchdog count, pending mask, and the count of the non-firing unit.
    int           edge_n;
    int           run_at;
    int           m_cnt;
    int           d2_cnt;
    logic [N-1:0] m_pend;

    cpu_sysctl u_dut (
        .CLK_6M(clk), .RST(rst), .MA(ma), .nMWE(mwe_n), .nVBLA(vbla_n),
        .nIRQ_SRC(src_n), .nMRES(nmres), .nIRQ(nirq), .WDOG_COUNT(wdog),
        .nMCS0(mcs0), .nMCS1(mcs1), .nMCS2(mcs2), .nMCS4(mcs4),
        .nMROM(mrom), .nLTH0(lth0), .nLTH1(lth1)
    );

    cpu_sysctl #(.WATCHDOG_ENABLE(1'b0)) u_dut_nowd (
        .CLK_6M(clk), .RST(rst), .MA(ma), .nMWE(mwe_n), .nVBLA(vbla_n),
        .nIRQ_SRC(src_n), .nMRES(nmres2), .nIRQ(nirq2), .WDOG_COUNT(wdog2),
        .nMCS0(cs2[6]), .nMCS1(cs2[5]), .nMCS2(cs2[4]), .nMCS4(cs2[3]),
        .nMROM(cs2[2]), .nLTH0(cs2[1]), .nLTH1(cs2[0])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    task automatic model_reset();
        edge_n = 0;
        run_at = RC;
        m_cnt  = 0;
        d2_cnt = 0;
        m_pend = '0;
    endtask

    // Advance one clock; the flags name events whose effect lands on this edge.
    task automatic clk_edge(input bit tk, input bit kk, input logic [N-1:0] ack,
                            input logic [N-1:0] src);
        bit run_now;
        @(posedge clk);
        run_now = (edge_n >= run_at);
        if (edge_n < RC) d2_cnt = 0;
        else if (kk) d2_cnt = 0;
        else if (tk && d2_cnt < WMAX) d2_cnt++;
        edge_n++;
        if (!run_now) begin
            m_cnt  = 0;
            m_pend = '0;
        end else if (tk && !kk && m_cnt == LIMIT - 1) begin
            run_at = edge_n + RC;
            m_cnt  = 0;
            m_pend = '0;
        end else begin
            if (kk) m_cnt = 0;
            else if (tk && m_cnt < WMAX) m_cnt++;
            m_pend = (m_pend & ~ack) | src;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) clk_edge(1'b0, 1'b0, '0, '0);
    endtask

    // One bus operation spanning four clocks: assert, hold, release, settle.
    task automatic do_op(input bit tk, input bit wr, input logic [4:0] page,
                         input logic [N-1:0] src);
        logic [N-1:0] ack;
        bit           kk;
        kk = wr && (page == KICK);
        for (int i = 0; i < N; i++) begin
            logic [4:0] p;
            p = ACK0 + 5'(i);
            ack[i] = wr && (page == p);
        end
        ma = page;
        if (wr) mwe_n = 1'b0;
        if (tk) vbla_n = 1'b0;
        src_n = ~src;
        clk_edge(1'b0, 1'b0, '0, '0);
        clk_edge(tk, kk, ack, src);
        mwe_n  = 1'b1;
        vbla_n = 1'b1;
        src_n  = '1;
        idle(2);
    endtask

    task automatic test_reset();
        rst = 1'b1; ma = '0; mwe_n = 1'b1; vbla_n = 1'b1; src_n = '1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (nmres !== 1'b0) $display("FAIL reset_nmres: got %0b expected 0", nmres);
        checks++;
        if (nirq !== 2'b11) $display("FAIL reset_nirq: got %b expected 11", nirq);
        checks++;
        if (wdog !== 8'd0) $display("FAIL reset_wdog: got %0d expected 0", wdog);
        if (nmres !== 1'b0) errors++;
        if (nirq !== 2'b11) errors++;
        if (wdog !== 8'd0) errors++;
        rst = 1'b0;
        model_reset();
        for (int i = 1; i <= RC; i++) begin
            logic exp;
            clk_edge(1'b0, 1'b0, '0, '0);
            exp = (i >= RC);
            checks++;
            if (nmres !== exp) begin
                errors++;
                $display("FAIL poweron_nmres edge %0d: got %0b expected %0b", i, nmres, exp);
            end
        end
        ma = 5'b00101;
        #1;
        checks++;
        if ({mcs0, mcs1, mcs2, mcs4, mrom, lth0, lth1} !== 7'b0111111) begin
            errors++;
            $display("FAIL poweron_cs: got %b expected 0111111",
                     {mcs0, mcs1, mcs2, mcs4, mrom, lth0, lth1});
        end
    endtask

    task automatic test_chip_selects();
        logic [6:0]  exp;
        logic [6:0]  got;
        logic [15:0] a;
        for (int n = 0; n < 40; n++) begin
            ma = 5'($urandom_range(31, 0));
            if (n == 0) ma = 5'b11010;
            if (n == 1) ma = 5'b11011;
            #1;
            a = {ma, 11'b0};
            exp[6] = ~(a >= 16'h2000 && a < 16'h4000);
            exp[5] = ~(a >= 16'h4000 && a < 16'h6000);
            exp[4] = ~(a < 16'h2000);
            exp[3] = ~(a >= 16'h6000 && a < 16'h8000);
            exp[2] = ~(a >= 16'h8000);
            exp[1] = ~(ma == 5'b11010);
            exp[0] = ~(ma == 5'b11011);
            got = {mcs0, mcs1, mcs2, mcs4, mrom, lth0, lth1};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL chip_select ma=%b: got %b expected %b", ma, got, exp);
            end
            checks++;
            if (cs2 !== exp) begin
                errors++;
                $display("FAIL chip_select_b ma=%b: got %b expected %b", ma, cs2, exp);
            end
        end
    endtask

    task automatic test_irq_set_ack();
        src_n = 2'b10;
        clk_edge(1'b0, 1'b0, '0, '0);
        checks++;
        if (nirq !== 2'b11) begin
            errors++;
            $display("FAIL irq_latency_e0: got %b expected 11", nirq);
        end
        clk_edge(1'b0, 1'b0, '0, 2'b01);
        checks++;
        if (nirq !== 2'b10) begin
            errors++;
            $display("FAIL irq_set_ch0: got %b expected 10", nirq);
        end
        src_n = 2'b11;
        idle(2);
        do_op(1'b0, 1'b1, ACK0, 2'b00);
        checks++;
        if (nirq !== 2'b11) begin
            errors++;
            $display("FAIL irq_ack_ch0: got %b expected 11", nirq);
        end
        do_op(1'b0, 1'b0, 5'($urandom_range(31, 0)), 2'b11);
        checks++;
        if (nirq !== 2'b00) begin
            errors++;
            $display("FAIL irq_set_both: got %b expected 00", nirq);
        end
        do_op(1'b0, 1'b1, ACK1, 2'b00);
        checks++;
        if (nirq !== 2'b10) begin
            errors++;
            $display("FAIL irq_ack_ch1_only: got %b expected 10", nirq);
        end
        do_op(1'b0, 1'b1, ACK0, 2'b00);
        checks++;
        if (nirq !== 2'b11) begin
            errors++;
            $display("FAIL irq_ack_ch0_again: got %b expected 11", nirq);
        end
    endtask

    task automatic test_long_write();
        do_op(1'b0, 1'b0, 5'b00000, 2'b01);
        ma = ACK0;
        mwe_n = 1'b0;
        clk_edge(1'b0, 1'b0, '0, '0);
        clk_edge(1'b0, 1'b0, 2'b01, '0);
        checks++;
        if (nirq !== 2'b11) begin
            errors++;
            $display("FAIL long_write_ack: got %b expected 11", nirq);
        end
        idle(4);
        src_n = 2'b10;
        clk_edge(1'b0, 1'b0, '0, '0);
        clk_edge(1'b0, 1'b0, '0, 2'b01);
        src_n = 2'b11;
        idle(6);
        checks++;
        if (nirq !== 2'b10) begin
            errors++;
            $display("FAIL long_write_single_event: got %b expected 10", nirq);
        end
        mwe_n = 1'b1;
        idle(2);
        do_op(1'b0, 1'b1, ACK0, 2'b00);
    endtask

    task automatic test_collision();
        do_op(1'b0, 1'b0, 5'b00011, 2'b10);
        do_op(1'b0, 1'b1, ACK1, 2'b10);
        checks++;
        if (nirq !== 2'b01) begin
            errors++;
            $display("FAIL collision_ch1: got %b expected 01", nirq);
        end
        do_op(1'b0, 1'b1, ACK0, 2'b01);
        checks++;
        if (nirq !== 2'b00) begin
            errors++;
            $display("FAIL collision_ch0: got %b expected 00", nirq);
        end
        do_op(1'b0, 1'b1, ACK0, 2'b00);
        do_op(1'b0, 1'b1, ACK1, 2'b00);
    endtask

    task automatic test_watchdog_timeout();
        do_op(1'b0, 1'b1, KICK, 2'b00);
        do_op(1'b0, 1'b0, 5'b00000, 2'b01);
        for (int i = 1; i < LIMIT; i++) begin
            do_op(1'b1, 1'b0, 5'($urandom_range(15, 0)), 2'b00);
            checks++;
            if (wdog !== 8'(i) || nmres !== 1'b1) begin
                errors++;
                $display("FAIL wd_count tick %0d: got count=%0d nmres=%0b expected count=%0d nmres=1",
                         i, wdog, nmres, i);
            end
        end
        vbla_n = 1'b0;
        clk_edge(1'b0, 1'b0, '0, '0);
        checks++;
        if (nmres !== 1'b1) begin
            errors++;
            $display("FAIL wd_fire_latency: got %0b expected 1", nmres);
        end
        clk_edge(1'b1, 1'b0, '0, '0);
        checks++;
        if (nmres !== 1'b0 || wdog !== 8'd0 || nirq !== 2'b11) begin
            errors++;
            $display("FAIL wd_fire: got nmres=%0b count=%0d nirq=%b expected 0 0 11",
                     nmres, wdog, nirq);
        end
        vbla_n = 1'b1;
        for (int k = 2; k <= RC + 1; k++) begin
            logic exp;
            if (k == 10) src_n = 2'b00;
            clk_edge(1'b0, 1'b0, '0, (k == 11) ? 2'b11 : 2'b00);
            exp = (k > RC);
            checks++;
            if (nmres !== exp || wdog !== 8'd0 || nirq !== 2'b11) begin
                errors++;
                $display("FAIL wd_hold edge %0d: got nmres=%0b count=%0d nirq=%b expected %0b 0 11",
                         k, nmres, wdog, nirq, exp);
            end
        end
        idle(4);
        checks++;
        if (nirq !== 2'b11) begin
            errors++;
            $display("FAIL wd_no_replay: got %b expected 11", nirq);
        end
        src_n = 2'b11;
        idle(2);
    endtask

    task automatic test_kick();
        do_op(1'b0, 1'b1, KICK, 2'b00);
        for (int i = 1; i < LIMIT; i++) do_op(1'b1, 1'b0, 5'b00100, 2'b00);
        checks++;
        if (wdog !== 8'd7) begin
            errors++;
            $display("FAIL kick_pre_count: got %0d expected 7", wdog);
        end
        do_op(1'b1, 1'b1, KICK, 2'b00);
        checks++;
        if (wdog !== 8'd0 || nmres !== 1'b1) begin
            errors++;
            $display("FAIL kick_with_tick: got count=%0d nmres=%0b expected 0 1", wdog, nmres);
        end
        idle(10);
        do_op(1'b1, 1'b0, 5'b00100, 2'b00);
        checks++;
        if (wdog !== 8'd1 || nmres !== 1'b1) begin
            errors++;
            $display("FAIL kick_then_tick: got count=%0d nmres=%0b expected 1 1", wdog, nmres);
        end
    endtask

    task automatic test_wdog_disabled();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        idle(RC);
        for (int t = 1; t <= 300; t++) begin
            do_op(1'b1, 1'b0, 5'b00110, 2'b00);
            checks++;
            if (wdog2 !== 8'(d2_cnt) || nmres2 !== 1'b1) begin
                errors++;
                $display("FAIL nowd_tick %0d: got count=%0d nmres=%0b expected count=%0d nmres=1",
                         t, wdog2, nmres2, d2_cnt);
            end
        end
        checks++;
        if (wdog2 !== 8'd255) begin
            errors++;
            $display("FAIL nowd_saturate: got %0d expected 255", wdog2);
        end
        checks++;
        if (nmres !== 1'(edge_n >= run_at) || wdog !== 8'(m_cnt)) begin
            errors++;
            $display("FAIL nowd_main_unit: got nmres=%0b count=%0d expected %0b %0d",
                     nmres, wdog, edge_n >= run_at, m_cnt);
        end
    endtask

    task automatic test_rst_mid_pulse();
        int f;
        do_op(1'b0, 1'b1, KICK, 2'b00);
        for (int i = 0; i < LIMIT; i++) do_op(1'b1, 1'b0, 5'b00001, 2'b00);
        f = run_at - RC;
        while (edge_n < f + 29) clk_edge(1'b0, 1'b0, '0, '0);
        checks++;
        if (nmres !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_in_hold: got %0b expected 0", nmres);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (nmres !== 1'b0 || wdog !== 8'd0 || nirq !== 2'b11) begin
            errors++;
            $display("FAIL rstmid_assert: got nmres=%0b count=%0d nirq=%b expected 0 0 11",
                     nmres, wdog, nirq);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 1; i <= RC; i++) begin
            logic exp;
            clk_edge(1'b0, 1'b0, '0, '0);
            exp = (i >= RC);
            checks++;
            if (nmres !== exp) begin
                errors++;
                $display("FAIL rstmid_hold edge %0d: got %0b expected %0b", i, nmres, exp);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            bit           tk;
            bit           wr;
            logic [4:0]   page;
            logic [N-1:0] src;
            int           r;
            tk = ($urandom_range(2, 0) == 0);
            wr = ($urandom_range(2, 0) == 0);
            r  = $urandom_range(9, 0);
            if (r == 0) page = KICK;
            else if (r <= 3) page = ACK0;
            else if (r <= 6) page = ACK1;
            else page = 5'($urandom_range(31, 0));
            src = ($urandom_range(1, 0) == 1) ? 2'($urandom_range(3, 0)) : 2'b00;
            if ($urandom_range(7, 0) == 0) idle($urandom_range(20, 1));
            do_op(tk, wr, page, src);
            checks++;
            if (nirq !== ~m_pend || wdog !== 8'(m_cnt) || nmres !== 1'(edge_n >= run_at)) begin
                errors++;
                $display("FAIL random op %0d: got nirq=%b count=%0d nmres=%0b expected %b %0d %0b",
                         n, nirq, wdog, nmres, ~m_pend, m_cnt, edge_n >= run_at);
            end
            checks++;
            if (wdog2 !== 8'(d2_cnt) || nmres2 !== 1'(edge_n >= RC)) begin
                errors++;
                $display("FAIL random_nowd op %0d: got count=%0d nmres=%0b expected %0d %0b",
                         n, wdog2, nmres2, d2_cnt, edge_n >= RC);
            end
        end
    endtask

    initial begin
        rst = 1'b1; ma = '0; mwe_n = 1'b1; vbla_n = 1'b1; src_n = '1;
        model_reset();
        test_reset();
        test_chip_selects();
        test_irq_set_ack();
        test_long_write();
        test_collision();
        test_watchdog_timeout();
        test_kick();
        test_wdog_disabled();
        test_rst_mid_pulse();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
